muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencing controller for the EX-stage multiply/divide resources. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and latches the operands. It drives the fixed-latency `mul` unit and the start/ready `div` unit, raises the EX stall request while a result is pending, and owns the architectural HI/LO registers. It replaces the ad-hoc combinational divider control in EX with a registered FSM that does not re-issue while the instruction is held.

## Interface
- `MUL_LAT`, 2: cycles `mul_result` needs after its operands become stable (≥1).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_mult`, `inst_multu`, `inst_div`, `inst_divu`, `inst_mthi`, `inst_mtlo` in 1 each: decoded EX instruction. Priority on multiple assertion: div > divu > mult > multu > mthi > mtlo.
- `src1`, `src2` in 32: rs/rt values. MTHI/MTLO use `src1`.
- `ex_hold` in 1: EX register will not advance this cycle (downstream stall).
- `flush` in 1: kill the in-flight operation.
- `stallreq` out 1: EX stall request (combinational).
- `busy` out 1: FSM not in IDLE.
- `hi_o`, `lo_o` out 32: current HI/LO.
- `div_start`, `div_signed`, `div_annul` out 1: to `div`.
- `div_opdata1`, `div_opdata2` out 32: to `div`.
- `div_result` in 64: {remainder, quotient}.
- `div_ready` in 1: `div` done.
- `mul_signed` out 1, `mul_ina`, `mul_inb` out 32: to `mul`.
- `mul_result` in 64: product.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE. Registers: `op_a`, `op_b`, `sgn`, `cnt` (width ≥ clog2(MUL_LAT+1)), `hi`, `lo`.
- IDLE:
  - div/divu: latch `src1`→`op_a`, `src2`→`op_b`, `sgn`=inst_div. Go to DIV_WAIT.
  - mult/multu: latch operands, `sgn`=inst_mult, `cnt`←MUL_LAT. Go to MUL_WAIT.
  - mthi: `hi`←`src1`. mtlo: `lo`←`src1`. Both take one cycle, no stall, stay in IDLE.
- MUL_WAIT: `cnt` decrements each cycle. When `cnt`==1: `hi`←`mul_result[63:32]`, `lo`←`mul_result[31:0]`, go to DONE.
- DIV_WAIT: `div_start`=1. When `div_ready`=1: `hi`←`div_result[63:32]` (remainder), `lo`←`div_result[31:0]` (quotient), go to DONE.
- DONE: no stall, so the instruction leaves EX. If `ex_hold`=0, go to IDLE. If `ex_hold`=1, stay in DONE. The still-present instruction must never restart an operation.
- `stallreq` = (IDLE & (mult|multu|div|divu) & ~flush) | MUL_WAIT | DIV_WAIT.
- `div_opdata1/2`, `mul_ina/inb` = `op_a`/`op_b`. `div_signed` = `mul_signed` = `sgn`. All are held constant outside IDLE.
- Divide by zero: no special handling. Whatever `div` returns on `div_ready` is written.
- `flush` in MUL_WAIT/DIV_WAIT/DONE: go to IDLE, no HI/LO write. `div_annul`=1 for that cycle if in DIV_WAIT.
- `flush` in IDLE: no operation starts. mthi/mtlo are suppressed.
- `flush` and `div_ready` (or `cnt`==1) in the same cycle: flush wins, HI/LO unchanged.
- Op inputs are ignored outside IDLE.

## Timing
- Reset: state IDLE; `hi`, `lo`, `op_a`, `op_b`, `sgn`, `cnt` = 0. Every output is 0 during and after reset until a new op arrives.
- Reset mid-operation returns to IDLE on the same edge, with no HI/LO write.
- MULT, cycle numbering from the cycle the op is seen (cycle 0):
  - cycle 0: IDLE, stall.
  - cycles 1..MUL_LAT: MUL_WAIT, stall.
  - cycle MUL_LAT+1: DONE; new HI/LO visible.
  - Total stall = MUL_LAT+1 cycles.
- DIV, with `div_ready` first high in cycle k (k≥1):
  - cycle 0: IDLE, stall.
  - cycles 1..k: DIV_WAIT, stall, `div_start`=1.
  - cycle k+1: DONE; `div_start`=0; HI/LO visible.
- MTHI/MTLO: HI/LO updated at the end of cycle 0, visible in cycle 1.
- `div_ready` is sampled only in DIV_WAIT.

## Test plan
- MULT, `src1`=0xFFFFFFFE (-2), `src2`=3, MUL_LAT=2, bench mul returns signed product -> `stallreq`=1 for cycles 0–2; cycle 3 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands -> `sgn`=0, `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIVU 100/7, div model ready at k=33 -> `div_start` high cycles 1–33; DONE at cycle 34 with `hi`=2, `lo`=14; `div_opdata1/2` constant throughout.
- DIV with ops held asserted and `ex_hold`=1 for 3 cycles in DONE -> stays in DONE, `stallreq`=0, no second `div_start`; returns to IDLE when `ex_hold` drops.
- `flush` in DIV_WAIT cycle 10 with HI=0x11, LO=0x22 -> `div_annul` pulse, IDLE next cycle, HI/LO unchanged. Repeat with `flush` coinciding with `div_ready` -> HI/LO unchanged.
- MTHI 0xDEADBEEF, then MTLO 0x12345678 on back-to-back cycles -> no stall; `hi_o`/`lo_o` update one cycle after each.
- `rst` asserted in MUL_WAIT -> next cycle IDLE, all outputs 0, HI/LO=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the fixed-latency multiplier and the
// start/ready divider; latches operands, raises the EX stall and owns HI/LO.
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_mult,
    input  logic        inst_multu,
    input  logic        inst_div,
    input  logic        inst_divu,
    input  logic        inst_mthi,
    input  logic        inst_mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result
);

    localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               sgn;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi;
    logic [31:0]        lo;

    logic               is_div_op;
    logic               is_mul_op;

    assign is_div_op = inst_div | inst_divu;
    assign is_mul_op = inst_mult | inst_multu;

    // Sequencer: ops are only accepted in IDLE, so a held instruction in DONE
    // can never re-issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            sgn   <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (is_div_op) begin
                            op_a  <= src1;
                            op_b  <= src2;
                            sgn   <= inst_div;
                            state <= DIV_WAIT;
                        end else if (is_mul_op) begin
                            op_a  <= src1;
                            op_b  <= src2;
                            sgn   <= inst_mult;
                            cnt   <= CNT_W'(MUL_LAT);
                            state <= MUL_WAIT;
                        end else if (inst_mthi) begin
                            hi <= src1;
                        end else if (inst_mtlo) begin
                            lo <= src1;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        hi    <= mul_result[63:32];
                        lo    <= mul_result[31:0];
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_ready) begin
                        hi    <= div_result[63:32];
                        lo    <= div_result[31:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (flush || !ex_hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and handshake outputs; forced low while reset is asserted.
    always_comb begin
        stallreq  = 1'b0;
        busy      = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        if (!rst) begin
            stallreq  = ((state == IDLE) && (is_div_op || is_mul_op) && !flush)
                        || (state == MUL_WAIT) || (state == DIV_WAIT);
            busy      = (state != IDLE);
            div_start = (state == DIV_WAIT);
            div_annul = (state == DIV_WAIT) && flush;
        end
    end

    assign hi_o        = hi;
    assign lo_o        = lo;
    assign div_opdata1 = op_a;
    assign div_opdata2 = op_b;
    assign mul_ina     = op_a;
    assign mul_inb     = op_b;
    assign div_signed  = sgn;
    assign mul_signed  = sgn;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed plus randomized checks of muldiv_ctrl against a
// behavioural model of the mul/div units and HI/LO results.
module tb_muldiv_ctrl;

    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_mult, inst_multu, inst_div, inst_divu, inst_mthi, inst_mtlo;
    logic [31:0] src1, src2;
    logic        ex_hold, flush;
    logic        stallreq, busy;
    logic [31:0] hi_o, lo_o;
    logic        div_start, div_signed, div_annul;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result;
    logic        div_ready;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int div_k   = 1;
    int dcyc    = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .inst_mult(inst_mult), .inst_multu(inst_multu),
        .inst_div(inst_div), .inst_divu(inst_divu),
        .inst_mthi(inst_mthi), .inst_mtlo(inst_mtlo),
        .src1(src1), .src2(src2), .ex_hold(ex_hold), .flush(flush),
        .stallreq(stallreq), .busy(busy), .hi_o(hi_o), .lo_o(lo_o),
        .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_result(div_result), .div_ready(div_ready),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result)
    );

    // Multiplier model: product available MUL_LAT (=2) cycles into the wait.
    logic [63:0] mul_pipe = '0;
    always @(posedge clk) begin
        if (mul_signed)
            mul_pipe <= 64'(longint'($signed(mul_ina)) * longint'($signed(mul_inb)));
        else
            mul_pipe <= {32'b0, mul_ina} * {32'b0, mul_inb};
    end
    assign mul_result = mul_pipe;

    // Divider model: ready on the div_k-th consecutive cycle of div_start.
    always @(posedge clk) dcyc <= div_start ? dcyc + 1 : 0;
    assign div_ready = div_start && (dcyc == div_k - 1);
    always_comb begin
        div_result = {div_opdata1, 32'hFFFF_FFFF};
        if (div_opdata2 != 32'd0) begin
            if (div_signed)
                div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                              32'($signed(div_opdata1) / $signed(div_opdata2))};
            else
                div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops;
        inst_mult = 0; inst_multu = 0; inst_div = 0; inst_divu = 0;
        inst_mthi = 0; inst_mtlo = 0;
    endtask

    task automatic set_op(input int kind);
        clear_ops();
        case (kind)
            0: inst_mult  = 1;
            1: inst_multu = 1;
            2: inst_div   = 1;
            default: inst_divu = 1;
        endcase
    endtask

    task automatic chk_ops(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg);
        chk({tag, " opdata1"}, div_opdata1, a);
        chk({tag, " opdata2"}, div_opdata2, b);
        chk({tag, " mul_ina"}, mul_ina, a);
        chk({tag, " mul_inb"}, mul_inb, b);
        chk({tag, " div_signed"}, div_signed, sg);
        chk({tag, " mul_signed"}, mul_signed, sg);
    endtask

    // Full op: kind 0 mult, 1 multu, 2 div, 3 divu; instruction held until it
    // leaves EX, with `hold` extra ex_hold cycles in DONE.
    task automatic run_op(input string tag, input int kind, input logic [31:0] a,
                          input logic [31:0] b, input int k, input int hold);
        logic [63:0] exp;
        int lat;
        int sa, sb;
        logic is_div, sg;
        sa = a; sb = b;
        is_div = (kind >= 2);
        sg = (kind == 0) || (kind == 2);
        case (kind)
            0: exp = 64'(longint'(sa) * longint'(sb));
            1: exp = {32'b0, a} * {32'b0, b};
            2: exp = {32'(sa % sb), 32'(sa / sb)};
            default: exp = {a % b, a / b};
        endcase
        lat = is_div ? k : int'(MUL_LAT);
        div_k = k;
        set_op(kind); src1 = a; src2 = b; ex_hold = 0; flush = 0;
        #1;
        chk({tag, " c0 stall"}, stallreq, 1'b1);
        chk({tag, " c0 busy"}, busy, 1'b0);
        tick();
        src1 = $urandom; src2 = $urandom;
        for (int c = 1; c <= lat; c++) begin
            #1;
            chk({tag, " wait stall"}, stallreq, 1'b1);
            chk({tag, " wait busy"}, busy, 1'b1);
            chk({tag, " wait div_start"}, div_start, is_div);
            chk_ops({tag, " wait"}, a, b, sg);
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            ex_hold = (h < hold);
            #1;
            chk({tag, " done stall"}, stallreq, 1'b0);
            chk({tag, " done busy"}, busy, 1'b1);
            chk({tag, " done div_start"}, div_start, 1'b0);
            chk({tag, " hi"}, hi_o, exp[63:32]);
            chk({tag, " lo"}, lo_o, exp[31:0]);
            tick();
        end
        ex_hold = 0; clear_ops();
        m_hi = exp[63:32]; m_lo = exp[31:0];
        #1;
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle hi"}, hi_o, m_hi);
        chk({tag, " idle lo"}, lo_o, m_lo);
        chk_ops({tag, " idle"}, a, b, sg);
    endtask

    // Start an op, flush it in wait cycle fc, expect HI/LO untouched.
    task automatic flush_op(input string tag, input int kind, input int k, input int fc);
        logic is_div;
        is_div = (kind >= 2);
        div_k = k;
        set_op(kind); src1 = 32'd1000; src2 = 32'd3; flush = 0;
        tick();
        for (int c = 1; c < fc; c++) tick();
        flush = 1;
        #1;
        chk({tag, " annul"}, div_annul, is_div);
        chk({tag, " flush stall"}, stallreq, 1'b1);
        tick();
        flush = 0; clear_ops();
        #1;
        chk({tag, " post busy"}, busy, 1'b0);
        chk({tag, " post annul"}, div_annul, 1'b0);
        chk({tag, " post hi"}, hi_o, m_hi);
        chk({tag, " post lo"}, lo_o, m_lo);
        tick();
        #1;
        chk({tag, " no restart"}, busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, stallreq, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " hi"}, hi_o, 32'd0);
        chk({tag, " lo"}, lo_o, 32'd0);
        chk({tag, " div_start"}, div_start, 1'b0);
        chk({tag, " div_annul"}, div_annul, 1'b0);
        chk_ops(tag, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1; clear_ops(); src1 = 0; src2 = 0; ex_hold = 0; flush = 0;
        tick(); tick();
        rst = 0;
        #1;
        chk_all_zero("reset");

        // MTHI then MTLO back-to-back
        inst_mthi = 1; src1 = 32'hDEADBEEF;
        #1;
        chk("mthi stall", stallreq, 1'b0);
        tick();
        clear_ops(); inst_mtlo = 1; src1 = 32'h12345678;
        #1;
        chk("mthi hi", hi_o, 32'hDEADBEEF);
        chk("mtlo stall", stallreq, 1'b0);
        chk("mtlo lo before", lo_o, 32'd0);
        tick();
        clear_ops();
        #1;
        chk("mtlo lo", lo_o, 32'h12345678);
        chk("mtlo hi kept", hi_o, 32'hDEADBEEF);
        tick();

        run_op("mult", 0, 32'hFFFFFFFE, 32'd3, 1, 0);
        tick();
        run_op("multu", 1, 32'hFFFFFFFE, 32'd3, 1, 0);
        tick();
        run_op("divu", 3, 32'd100, 32'd7, 33, 0);
        tick();
        run_op("div hold", 2, 32'hFFFFFFF9, 32'd2, 4, 3);
        tick();

        // seed HI/LO for the flush cases
        inst_mthi = 1; src1 = 32'h11; tick();
        clear_ops(); inst_mtlo = 1; src1 = 32'h22; tick();
        clear_ops(); m_hi = 32'h11; m_lo = 32'h22;
        flush_op("flush div10", 2, 33, 10);
        flush_op("flush div rdy", 3, 5, 5);
        flush_op("flush mul last", 0, 1, int'(MUL_LAT));

        // flush in IDLE suppresses op start and MTHI
        inst_mult = 1; src1 = 32'd9; src2 = 32'd9; flush = 1;
        #1;
        chk("idle flush stall", stallreq, 1'b0);
        tick();
        clear_ops(); inst_mthi = 1; src1 = 32'hAAAA5555;
        #1;
        chk("idle flush busy", busy, 1'b0);
        tick();
        clear_ops(); flush = 0;
        #1;
        chk("idle flush mthi", hi_o, m_hi);
        chk("idle flush busy2", busy, 1'b0);
        tick();

        // div and mult asserted together: divide wins, signed
        inst_div = 1; inst_mult = 1; src1 = 32'd50; src2 = 32'd8; div_k = 2;
        tick();
        #1;
        chk("prio div_start", div_start, 1'b1);
        chk("prio sgn", div_signed, 1'b1);
        flush = 1; tick(); flush = 0; clear_ops(); tick();

        for (int i = 0; i < 24; i++) begin
            int kind;
            logic [31:0] a, b;
            kind = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(8, 31);
            if (b == 32'd0) b = 32'd1;
            if (kind == 2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            run_op($sformatf("rand%0d", i), kind, a, b,
                   $urandom_range(1, 8), $urandom_range(0, 2));
            tick();
        end

        // reset during MUL_WAIT
        inst_mult = 1; src1 = 32'd5; src2 = 32'd6;
        tick();
        rst = 1;
        #1;
        chk("rst mid busy", busy, 1'b0);
        chk("rst mid stall", stallreq, 1'b0);
        tick();
        rst = 0; clear_ops();
        #1;
        chk_all_zero("rst mid");
        tick(); tick();
        #1;
        chk("rst mid no write hi", hi_o, 32'd0);
        chk("rst mid no write lo", lo_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
